// File: rtl/vata_readout_arbiter.sv
// Round-robin arbiter for the shared VATA event-readout path.
//
// state | meaning
// IDLE  | no grant; arbitrate among requesters when enabled
// GRANT | one core owns the readout path; watchdog running
// GAP   | one-cycle bus turnaround with no grant before re-arbitration
module vata_readout_arbiter #(
  parameter int N_VATA         = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_CNT_W       = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic                clear_stats,
  input  logic [N_VATA-1:0]   req,
  input  logic [N_VATA-1:0]   done,
  output logic [N_VATA-1:0]   grant,
  output logic                grant_valid,
  output logic [4:0]          grant_id,
  output logic                busy,
  output logic                timeout_pulse,
  output logic [TO_CNT_W-1:0] timeout_count,
  output logic [N_VATA-1:0]   timeout_mask
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N_VATA-1:0] ONE_HOT0 = {{(N_VATA-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            ptr_q, ptr_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [N_VATA-1:0]     grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [4:0]            grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic                  timeout_pulse_q, timeout_pulse_d;
  logic [TO_CNT_W-1:0]   timeout_count_q, timeout_count_d;
  logic [N_VATA-1:0]     timeout_mask_q, timeout_mask_d;

  logic                  win_found;
  logic [4:0]            win_idx;
  logic [5:0]            arb_idx;
  logic [5:0]            ptr_nxt;
  logic [N_VATA-1:0]     req_sh;
  logic                  done_hit;
  logic                  req_hit;
  logic                  release_now;
  logic                  timeout_hit;

  // Rotating priority search: first requester at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_idx   = '0;
    req_sh    = '0;
    for (int i = 0; i < N_VATA; i++) begin
      arb_idx = 6'(ptr_q) + 6'(i);
      if (arb_idx >= 6'(N_VATA)) arb_idx = arb_idx - 6'(N_VATA);
      req_sh = req >> arb_idx;
      if (!win_found && req_sh[0]) begin
        win_found = 1'b1;
        win_idx   = arb_idx[4:0];
      end
    end
    ptr_nxt = 6'(win_idx) + 6'd1;
    if (ptr_nxt == 6'(N_VATA)) ptr_nxt = '0;
  end

  // Next-state and registered-output computation for the grant FSM
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    wd_d            = wd_q;
    grant_d         = grant_q;
    grant_id_d      = grant_id_q;
    timeout_pulse_d = 1'b0;
    timeout_count_d = timeout_count_q;
    timeout_mask_d  = timeout_mask_q;

    // Masking with the grant vector avoids indexing by grant_id; only the
    // owner's done/req lines matter.
    done_hit    = |(done & grant_q);
    req_hit     = |(req & grant_q);
    timeout_hit = (wd_q == WD_LIM);
    release_now = done_hit || !req_hit || timeout_hit;

    case (state_q)
      ST_IDLE: begin
        if (enable && win_found) begin
          grant_d    = ONE_HOT0 << win_idx;
          grant_id_d = win_idx;
          ptr_d      = ptr_nxt[4:0];
          wd_d       = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d = wd_q + WD_W'(1);
        if (release_now) begin
          grant_d = '0;
          state_d = ST_GAP;
          // A completed or abandoned readout is never counted as a hang
          if (timeout_hit && !done_hit && req_hit) begin
            timeout_pulse_d = 1'b1;
            timeout_mask_d  = timeout_mask_q | grant_q;
            if (timeout_count_q != '1) timeout_count_d = timeout_count_q + TO_CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (clear_stats) begin
      timeout_count_d = '0;
      timeout_mask_d  = '0;
    end

    busy_d        = (state_d != ST_IDLE);
    grant_valid_d = |grant_d;
  end

  // Single register bank for FSM state and all outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      wd_q            <= '0;
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_id_q      <= '0;
      busy_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_count_q <= '0;
      timeout_mask_q  <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      wd_q            <= wd_d;
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_id_q      <= grant_id_d;
      busy_q          <= busy_d;
      timeout_pulse_q <= timeout_pulse_d;
      timeout_count_q <= timeout_count_d;
      timeout_mask_q  <= timeout_mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_count = timeout_count_q;
  assign timeout_mask  = timeout_mask_q;

endmodule

// File: tb/tb_vata_readout_arbiter.sv
// Scoreboard bench for vata_readout_arbiter: expected grant order is queued
// as requests are driven and checked when each grant rises.
module tb_vata_readout_arbiter;

  localparam int N  = 12;
  localparam int TO = 4096;
  localparam int CW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          enable;
  logic          clear_stats;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [4:0]    grant_id;
  logic          busy;
  logic          timeout_pulse;
  logic [CW-1:0] timeout_count;
  logic [N-1:0]  timeout_mask;

  vata_readout_arbiter #(.N_VATA(N), .TIMEOUT_CYCLES(TO), .TO_CNT_W(CW)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .clear_stats   (clear_stats),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .timeout_count (timeout_count),
    .timeout_mask  (timeout_mask)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Grant monitor: pops the scoreboard on every rising grant
  logic gv_prev = 1'b0;
  int   low_cnt = 0;
  int   e;
  always @(negedge ACLK) begin
    if (grant_valid && !gv_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e));
        chk("grant_onehot", 32'(grant), 32'(1) << e);
        chk("grant_spacing", 32'(low_cnt >= 2), 32'd1);
      end
      low_cnt = 0;
    end else if (!grant_valid) begin
      low_cnt++;
    end
    gv_prev = grant_valid;
  end

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge ACLK);
      got = grant_valid;
    end
    chk("grant_wait", 32'(got), 32'd1);
    id = int'(grant_id);
  endtask

  // Grant one core and let the watchdog reclaim it, optionally clearing stats
  // in the very cycle the watchdog fires.
  task automatic run_timeout(input int core, input bit clr_at_to);
    int id;
    req = '0;
    req[core] = 1'b1;
    exp_q.push_back(core);
    wait_grant(10, id);
    repeat (TO - 1) @(negedge ACLK);
    chk("to_held", 32'(grant_valid), 32'd1);
    if (clr_at_to) clear_stats = 1'b1;
    @(negedge ACLK);
    clear_stats = 1'b0;
    req = '0;
    chk("to_release", 32'(grant_valid), 32'd0);
    chk("to_pulse", 32'(timeout_pulse), 32'd1);
    @(negedge ACLK);
    chk("to_pulse_once", 32'(timeout_pulse), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int gid;
    ARESETN     = 1'b0;
    enable      = 1'b1;
    clear_stats = 1'b0;
    req         = 12'hFFF;
    done        = '0;

    // Reset held with all requests asserted
    repeat (20) begin
      @(negedge ACLK);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stats", 32'(timeout_count) | 32'(timeout_mask) | 32'(timeout_pulse) | 32'(grant_id), 32'd0);
    end
    exp_q.push_back(0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_release_latency", 32'(grant_valid), 32'd1);
    req = '0;
    repeat (3) @(negedge ACLK);

    // Round-robin over cores 0..3 with done 10 cycles after each grant
    do_reset();
    req = 12'h00F;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, gid);
      if (k == 1) begin
        done = 12'h004;
        @(negedge ACLK);
        done = '0;
        chk("foreign_done_ignored", 32'(grant), 32'h2);
        repeat (8) @(negedge ACLK);
      end else begin
        repeat (9) @(negedge ACLK);
      end
      done = '0;
      done[gid] = 1'b1;
      if (k == 4) req = '0;
      @(negedge ACLK);
      done = '0;
      chk("done_release", 32'(grant_valid), 32'd0);
      chk("done_no_pulse", 32'(timeout_pulse), 32'd0);
    end
    repeat (3) @(negedge ACLK);

    // Watchdog release of core 5
    do_reset();
    run_timeout(5, 1'b0);
    chk("to_count", 32'(timeout_count), 32'd1);
    chk("to_mask", 32'(timeout_mask), 32'h020);

    // done in the cycle the watchdog reaches its limit
    req = 12'h020;
    exp_q.push_back(5);
    wait_grant(10, gid);
    repeat (TO - 1) @(negedge ACLK);
    chk("col_held", 32'(grant_valid), 32'd1);
    done[5] = 1'b1;
    @(negedge ACLK);
    done = '0;
    req  = '0;
    chk("col_release", 32'(grant_valid), 32'd0);
    chk("col_no_pulse", 32'(timeout_pulse), 32'd0);
    chk("col_count", 32'(timeout_count), 32'd1);
    repeat (3) @(negedge ACLK);

    // enable gating, latency, enable drop mid-grant, abort by req drop
    enable = 1'b0;
    req    = 12'h001;
    repeat (5) begin
      @(negedge ACLK);
      chk("disabled_no_grant", 32'(grant_valid), 32'd0);
    end
    exp_q.push_back(0);
    enable = 1'b1;
    @(negedge ACLK);
    chk("enable_latency", 32'(grant), 32'h001);
    enable = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("enable_drop_holds", 32'(grant), 32'h001);
    req = '0;
    @(negedge ACLK);
    chk("abort_release", 32'(grant_valid), 32'd0);
    chk("abort_no_pulse", 32'(timeout_pulse), 32'd0);
    chk("abort_count", 32'(timeout_count), 32'd1);
    enable = 1'b1;
    repeat (3) @(negedge ACLK);

    // Asynchronous reset during grant[3], then pointer back at 0
    req = 12'h008;
    exp_q.push_back(3);
    wait_grant(10, gid);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_stats", 32'(timeout_count) | 32'(timeout_mask), 32'd0);
    req = 12'h018;
    @(negedge ACLK);
    @(negedge ACLK);
    exp_q.push_back(3);
    ARESETN = 1'b1;
    wait_grant(5, gid);
    req = '0;
    repeat (3) @(negedge ACLK);

    // Statistics clearing, including clear coinciding with a timeout
    run_timeout(2, 1'b0);
    chk("stats_count_a", 32'(timeout_count), 32'd1);
    chk("stats_mask_a", 32'(timeout_mask), 32'h004);
    run_timeout(7, 1'b1);
    chk("clr_win_count", 32'(timeout_count), 32'd0);
    chk("clr_win_mask", 32'(timeout_mask), 32'd0);
    run_timeout(2, 1'b0);
    chk("stats_count_b", 32'(timeout_count), 32'd1);
    clear_stats = 1'b1;
    @(negedge ACLK);
    clear_stats = 1'b0;
    chk("clr_count", 32'(timeout_count), 32'd0);
    chk("clr_mask", 32'(timeout_mask), 32'd0);

    repeat (3) @(negedge ACLK);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
